// File: rtl/seg7_bcd_display_engine.sv
// seg7_bcd_display_engine
//   Converts N_CH unsigned channel values to DIGITS seven-segment digits each.
//   A single shift-add-3 (double-dabble) datapath is shared by all channels.
//   Results are staged, then written to hex/overflow in one cycle (COMMIT).
//
// Ports
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   in_valid  transaction offered; accepted when in_ready is also high
//   in_ready  high only in IDLE
//   in_value  channel c at [c*IN_W +: IN_W]
//   in_dp     decimal point per digit, bit c*DIGITS+d
//   hex       channel c digit d at [(c*DIGITS+d)*8 +: 8]; bit0=a .. bit6=g, bit7=dp
//   overflow  per-channel value > 10^DIGITS-1 in the last committed transaction
//   done      one-cycle pulse in the first cycle the new hex/overflow are visible
//
// Build option
//   LEADING_ZERO_BLANK_EN  blank leading zero digits (never digit 0) in
//                          non-overflowed channels.
module seg7_bcd_display_engine #(
  parameter int N_CH           = 3,
  parameter int IN_W           = 7,
  parameter int DIGITS         = 2,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CH*IN_W-1:0]       in_value,
  input  logic [N_CH*DIGITS-1:0]     in_dp,
  output logic [N_CH*DIGITS*8-1:0]   hex,
  output logic [N_CH-1:0]            overflow,
  output logic                       done
);

  localparam int ACC_W = 4*((IN_W+2)/3) + 4;
  localparam int NIB   = ACC_W/4;
  localparam int BCD_W = 4*DIGITS;
  localparam int EXT_W = (ACC_W > BCD_W) ? ACC_W : BCD_W;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [7:0] POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

  state_t                        r_state, w_next;
  logic [N_CH*IN_W-1:0]          r_val;
  logic [N_CH*DIGITS-1:0]        r_dp;
  logic [CH_W-1:0]               r_ch;
  logic [BIT_W-1:0]              r_bit;
  logic [ACC_W-1:0]              r_acc;
  logic [IN_W-1:0]               r_sr;
  logic [N_CH-1:0][BCD_W-1:0]    r_stg_bcd;
  logic [N_CH-1:0]               r_stg_ovf;
  logic [N_CH*DIGITS*8-1:0]      r_hex;
  logic [N_CH-1:0]               r_ovf;
  logic                          r_done;

  logic                          w_bit_last;
  logic                          w_ch_last;
  logic [ACC_W-1:0]              w_acc_adj;
  logic [ACC_W-1:0]              w_acc_new;
  logic [EXT_W-1:0]              w_acc_ext;
  logic [N_CH*DIGITS*8-1:0]      w_hex_enc;

  function automatic logic [6:0] seg_lut(input logic [3:0] v);
    case (v)
      4'd0:    seg_lut = 7'h3F;
      4'd1:    seg_lut = 7'h06;
      4'd2:    seg_lut = 7'h5B;
      4'd3:    seg_lut = 7'h4F;
      4'd4:    seg_lut = 7'h66;
      4'd5:    seg_lut = 7'h6D;
      4'd6:    seg_lut = 7'h7D;
      4'd7:    seg_lut = 7'h07;
      4'd8:    seg_lut = 7'h7F;
      4'd9:    seg_lut = 7'h6F;
      default: seg_lut = 7'h00;
    endcase
  endfunction

  assign w_bit_last = (r_bit == BIT_W'(IN_W-1));
  assign w_ch_last  = (r_ch == CH_W'(N_CH-1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = S_LOAD;
      S_LOAD:   w_next = S_SHIFT;
      S_SHIFT:  if (w_bit_last) w_next = w_ch_last ? S_COMMIT : S_LOAD;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Double-dabble step: correct nibbles >= 5, then shift the next input bit in.
  // The top accumulator bit can never be set by a valid conversion, so the
  // truncating cast drops nothing.
  always_comb begin
    w_acc_adj = r_acc;
    for (int n = 0; n < NIB; n++)
      if (r_acc[4*n +: 4] >= 4'd5) w_acc_adj[4*n +: 4] = r_acc[4*n +: 4] + 4'd3;
    w_acc_new = ACC_W'({w_acc_adj, r_sr[IN_W-1]});
    w_acc_ext = EXT_W'(w_acc_new);
  end

  // Segment encoding of the staged results; only sampled in COMMIT.
  always_comb begin
    w_hex_enc = '0;
    for (int c = 0; c < N_CH; c++) begin
`ifdef LEADING_ZERO_BLANK_EN
      logic lead;
      lead = 1'b1;
`endif
      for (int d = DIGITS-1; d >= 0; d--) begin
        logic [3:0] dig;
        logic [6:0] seg;
        dig = r_stg_bcd[c][4*d +: 4];
        seg = seg_lut(dig);
`ifdef LEADING_ZERO_BLANK_EN
        // Walk from the top digit down; blank while only zeros seen so far.
        if (lead && dig == 4'd0 && d != 0) seg = 7'h00;
        else                               lead = 1'b0;
`endif
        if (r_stg_ovf[c]) seg = 7'h40;
        w_hex_enc[(c*DIGITS+d)*8 +: 8] = {r_dp[c*DIGITS+d], seg} ^ POL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_val     <= '0;
      r_dp      <= '0;
      r_ch      <= '0;
      r_bit     <= '0;
      r_acc     <= '0;
      r_sr      <= '0;
      r_stg_bcd <= '0;
      r_stg_ovf <= '0;
      r_hex     <= {(N_CH*DIGITS){POL}};
      r_ovf     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_val <= in_value;
            r_dp  <= in_dp;
            r_ch  <= '0;
          end
        end
        S_LOAD: begin
          r_acc <= '0;
          r_sr  <= r_val[r_ch*IN_W +: IN_W];
          r_bit <= '0;
        end
        S_SHIFT: begin
          r_acc <= w_acc_new;
          r_sr  <= r_sr << 1;
          r_bit <= r_bit + BIT_W'(1);
          if (w_bit_last) begin
            r_stg_bcd[r_ch] <= w_acc_ext[BCD_W-1:0];
            r_stg_ovf[r_ch] <= ((w_acc_ext >> BCD_W) != '0);
            r_ch            <= r_ch + CH_W'(1);
          end
        end
        S_COMMIT: begin
          r_hex  <= w_hex_enc;
          r_ovf  <= r_stg_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign hex      = r_hex;
  assign overflow = r_ovf;
  assign done     = r_done;

endmodule
